bytecode_fetch: RTL

- Instruction-fetch front end that feeds the bytecode decoder.
- Reads variable-length JVM bytecode (opcode plus 0–2 operand bytes) one byte at a time from byte-wide instruction memory.
- Packs the bytes into one 32-bit instruction word and offers it to the decoder over the decoder's start/ready handshake.
- Sits between instruction memory and the decoder, and owns the program counter.

---
 rtl/bytecode_fetch.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bytecode_fetch.sv
// ---------------------------------------------------------------------------
// bytecode_fetch
//
// Instruction-fetch front end for the bytecode decoder. Reads a JVM
// instruction (opcode plus 0-2 operand bytes) one byte at a time from a
// byte-wide instruction memory. Packs the bytes into one instruction word
// and offers that word to the decoder over a start/ready handshake. This
// block owns the program counter.
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous, active-low reset
//   run             level; 1 allows fetching, 0 parks in IDLE after hand-off
//   pc_load         one-cycle strobe; load pc_value as the new fetch address
//   pc_value        new program counter
//   mem_start       one-cycle memory read request
//   mem_address     byte address, valid while mem_start=1
//   mem_ready       one-cycle strobe, mem_data valid
//   mem_data        returned byte
//   dec_start       instruction_out valid, held until accepted
//   dec_ready       decoder accepts when dec_start and dec_ready are both 1
//   instruction_out packed word {opcode, operand1, operand2, 8'h00}
//   pc              address of the opcode being fetched or offered
// ---------------------------------------------------------------------------
module bytecode_fetch #(
  parameter int byte_width   = 8,
  parameter int width_out    = 32,
  parameter int address_size = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    pc_load,
  input  logic [address_size-1:0] pc_value,
  output logic                    mem_start,
  output logic [address_size-1:0] mem_address,
  input  logic                    mem_ready,
  input  logic [byte_width-1:0]   mem_data,
  output logic                    dec_start,
  input  logic                    dec_ready,
  output logic [width_out-1:0]    instruction_out,
  output logic [address_size-1:0] pc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ISSUE = 2'd3;

  localparam logic [address_size-1:0] addr_one = address_size'(1);

  logic [1:0]              state, state_n;
  logic [address_size-1:0] fetch_addr, fetch_addr_n;
  logic [address_size-1:0] pc_n;
  logic [1:0]              byte_idx, byte_idx_n;
  logic [1:0]              op_count, op_count_n;
  logic [width_out-1:0]    instr_n;
  logic                    done;

  // Number of operand bytes that follow a given opcode.
  function automatic logic [1:0] operand_count(input logic [byte_width-1:0] op);
    logic [1:0] cnt;
    cnt = 2'd0;
    if (op == 8'h10 || op == 8'h12 || (op >= 8'h15 && op <= 8'h19) ||
        (op >= 8'h36 && op <= 8'h3A) || op == 8'hA9 || op == 8'hBC)
      cnt = 2'd1;
    else if (op == 8'h11 || op == 8'h13 || op == 8'h14 || op == 8'h84 ||
             (op >= 8'h99 && op <= 8'hA8) || (op >= 8'hB2 && op <= 8'hB8) ||
             op == 8'hBB || op == 8'hBD || op == 8'hC0 || op == 8'hC1 ||
             op == 8'hC6 || op == 8'hC7)
      cnt = 2'd2;
    return cnt;
  endfunction

  // Next-state logic. instruction_out itself is the slot storage, so the
  // word under construction is what gets offered once complete. pc_load
  // overrides everything that the normal state flow would do this cycle.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    fetch_addr_n = fetch_addr;
    byte_idx_n   = byte_idx;
    op_count_n   = op_count;
    instr_n      = instruction_out;
    done         = 1'b0;

    case (state)
      IDLE: begin
        if (run) state_n = REQ;
      end
      REQ: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (mem_ready) begin
          case (byte_idx)
            2'd0: begin
              instr_n[width_out-1 -: byte_width] = mem_data;
              op_count_n = operand_count(mem_data);
              done       = (operand_count(mem_data) == 2'd0);
            end
            2'd1: begin
              instr_n[width_out-byte_width-1 -: byte_width] = mem_data;
              done = (op_count == 2'd1);
            end
            default: begin
              instr_n[width_out-2*byte_width-1 -: byte_width] = mem_data;
              done = 1'b1;
            end
          endcase
          fetch_addr_n = fetch_addr + addr_one;
          byte_idx_n   = byte_idx + 2'd1;
          state_n      = done ? ISSUE : REQ;
        end
      end
      default: begin
        if (dec_ready) begin
          pc_n         = pc + addr_one + address_size'(op_count);
          fetch_addr_n = pc_n;
          byte_idx_n   = 2'd0;
          op_count_n   = 2'd0;
          instr_n      = '0;
          state_n      = run ? REQ : IDLE;
        end
      end
    endcase

    if (pc_load) begin
      pc_n         = pc_value;
      fetch_addr_n = pc_value;
      byte_idx_n   = 2'd0;
      op_count_n   = 2'd0;
      instr_n      = '0;
      state_n      = run ? REQ : IDLE;
    end
  end

  // State and output registers. mem_start/dec_start are derived from the
  // next state so they are registered and line up with REQ/ISSUE exactly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      pc              <= '0;
      fetch_addr      <= '0;
      byte_idx        <= 2'd0;
      op_count        <= 2'd0;
      instruction_out <= '0;
      mem_start       <= 1'b0;
      mem_address     <= '0;
      dec_start       <= 1'b0;
    end else begin
      state           <= state_n;
      pc              <= pc_n;
      fetch_addr      <= fetch_addr_n;
      byte_idx        <= byte_idx_n;
      op_count        <= op_count_n;
      instruction_out <= instr_n;
      mem_start       <= (state_n == REQ);
      mem_address     <= fetch_addr_n;
      dec_start       <= (state_n == ISSUE);
    end
  end

endmodule
